// File: rtl/num_syst_pkg.sv
// rtl/num_syst_pkg.sv - shared types and constants for the num_syst conversion engines
//
// Purpose: state encoding and sizing helpers used by bcd_to_bin and rdd_iter.
// Ports:   none (package).
package num_syst_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam int BCD_MAX_DIGIT = 9;

  // One shift-and-correct iteration per input bit.
  function automatic int iters_f(input int digits);
    return 4 * digits;
  endfunction

  // Counter must be able to hold 0..ITERS.
  function automatic int cnt_w_f(input int digits);
    return $clog2(4 * digits + 1);
  endfunction

endpackage

// File: rtl/rdd_iter.sv
// rtl/rdd_iter.sv - one combinational reverse double-dabble step
//
// Purpose: shift the {bcd, bin} vector right by one, then subtract 3 from every
//          BCD nibble of the upper field that is >= 8 (inverse of dd_iter).
// Ports:
//   din   in  8*DIGITS  current {bcd field, binary field}
//   dout  out 8*DIGITS  value after one iteration
module rdd_iter
  import num_syst_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [8*DIGITS-1:0] din,
  output logic [8*DIGITS-1:0] dout
);

  localparam int HALF = 4 * DIGITS;

  logic [8*DIGITS-1:0] shifted;

  always_comb begin
    shifted = din >> 1;
    dout    = shifted;
    for (int i = 0; i < DIGITS; i++) begin
      // A nibble >= 8 after the shift means a decimal 10 was halved into it,
      // which in binary weighting is 3 too large (8 vs 5).
      if (shifted[HALF + 4*i +: 4] >= 4'd8) begin
        dout[HALF + 4*i +: 4] = shifted[HALF + 4*i +: 4] - 4'd3;
      end
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD to binary converter with start/done handshake
//
// Purpose: converts a packed BCD number to binary using reverse double dabble,
//          one iteration per clock; flags invalid digits and results wider
//          than BIN_W.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   start     in   request a conversion (sampled only while idle)
//   bcd_in    in   packed BCD, digit 0 in [3:0]
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when results update
//   bin_out   out  converted value truncated to BIN_W bits
//   overflow  out  full result did not fit in BIN_W bits
//   bcd_err   out  some input digit was > 9
module bcd_to_bin
  import num_syst_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  overflow,
  output logic                  bcd_err
);

  localparam int ITERS = iters_f(DIGITS);
  localparam int CNT_W = cnt_w_f(DIGITS);
  localparam int HALF  = 4 * DIGITS;

  state_t              state;
  logic [2*HALF-1:0]   sr;
  logic [2*HALF-1:0]   sr_next;
  logic [CNT_W-1:0]    cnt;
  logic                digit_bad;
  logic [HALF-1:0]     bin_full;

  rdd_iter #(.DIGITS(DIGITS)) u_rdd_iter (
    .din  (sr),
    .dout (sr_next)
  );

  assign bin_full = sr_next[HALF-1:0];

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'(BCD_MAX_DIGIT)) begin
        digit_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bin_out  <= '0;
      overflow <= 1'b0;
      bcd_err  <= 1'b0;
      sr       <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {bcd_in, {HALF{1'b0}}};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= digit_bad ? ERR : SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          // Last iteration: results come straight from the step output so the
          // done pulse lands on the same edge as the final shift.
          if (cnt == CNT_W'(ITERS - 1)) begin
            bin_out  <= bin_full[BIN_W-1:0];
            overflow <= (bin_full >> BIN_W) != '0;
            bcd_err  <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        ERR: begin
          bin_out  <= '0;
          overflow <= 1'b0;
          bcd_err  <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - self-checking bench for bcd_to_bin
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [7:0]  bin_out;
  logic        overflow;
  logic        bcd_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  bcd_to_bin #(.DIGITS(3), .BIN_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .bin_out  (bin_out),
    .overflow (overflow),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal value from the digits, plain arithmetic.
  function automatic void model(input logic [11:0] bcd, output int lat,
                                output logic [7:0] b, output logic o, output logic e);
    int v;
    int d;
    v = 0;
    e = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    if (e) begin
      b = 8'd0; o = 1'b0; lat = 1;
    end else begin
      b = 8'(v % 256); o = (v > 255); lat = 12;
    end
  endfunction

  // Stimulus helper: must be entered #1 after an edge with the DUT idle.
  // Returns latency (-1 on timeout), captured outputs, and count of cycles
  // where busy was low before done.
  task automatic do_conv(input logic [11:0] bcd, output int lat, output logic [7:0] b,
                         output logic o, output logic e, output int busy_bad, output int done_cyc);
    start = 1'b1; bcd_in = bcd;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_bad = 0; b = 8'h00; o = 1'b0; e = 1'b0; done_cyc = -1;
    if (!busy) busy_bad++;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c; b = bin_out; o = overflow; e = bcd_err; done_cyc = cyc;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bcd_in = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, bin_out, overflow, bcd_err} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b bin=%h ov=%b err=%b, want all 0",
               busy, done, bin_out, overflow, bcd_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_max_fit();
    int lat, bb, dc; logic [7:0] b; logic o, e;
    do_conv(12'h255, lat, b, o, e, bb, dc);
    n_cmp++;
    if (lat !== 12) begin n_err++; $display("FAIL max_fit_latency: got %0d want 12", lat); end
    n_cmp++;
    if ({b, o, e} !== {8'hFF, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL max_fit_result: got bin=%h ov=%b err=%b want FF 0 0", b, o, e);
    end
    n_cmp++;
    if (bb !== 0) begin n_err++; $display("FAIL max_fit_busy: busy low %0d cycles, want 0", bb); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL max_fit_busy_done: got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vals [3] = '{12'h000, 12'h099, 12'h100};
    logic [7:0]  want [3] = '{8'h00, 8'h63, 8'h64};
    int lat, bb, dc, prev; logic [7:0] b; logic o, e;
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      do_conv(vals[k], lat, b, o, e, bb, dc);
      n_cmp++;
      if (b !== want[k] || o !== 1'b0 || e !== 1'b0 || lat !== 12) begin
        n_err++;
        $display("FAIL b2b_result[%0d]: got bin=%h ov=%b err=%b lat=%0d want %h 0 0 12",
                 k, b, o, e, lat, want[k]);
      end
      if (prev >= 0) begin
        n_cmp++;
        if (dc - prev !== 13) begin
          n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want 13", k, dc - prev);
        end
      end
      prev = dc;
    end
  endtask

  task automatic test_overflow();
    int lat, bb, dc; logic [7:0] b; logic o, e;
    do_conv(12'h999, lat, b, o, e, bb, dc);
    n_cmp++;
    if ({b, o, e} !== {8'hE7, 1'b1, 1'b0} || lat !== 12) begin
      n_err++; $display("FAIL ovf_999: got bin=%h ov=%b err=%b lat=%0d want E7 1 0 12", b, o, e, lat);
    end
    do_conv(12'h256, lat, b, o, e, bb, dc);
    n_cmp++;
    if ({b, o, e} !== {8'h00, 1'b1, 1'b0} || lat !== 12) begin
      n_err++; $display("FAIL ovf_256: got bin=%h ov=%b err=%b lat=%0d want 00 1 0 12", b, o, e, lat);
    end
  endtask

  task automatic test_bcd_err();
    int lat, bb, dc; logic [7:0] b; logic o, e;
    do_conv(12'h1A5, lat, b, o, e, bb, dc);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL err_latency: got %0d want 1", lat); end
    n_cmp++;
    if ({b, o, e} !== {8'h00, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL err_result: got bin=%h ov=%b err=%b want 00 0 1", b, o, e);
    end
  endtask

  task automatic test_ignore_start();
    int ndone, first;
    logic [7:0] b;
    start = 1'b1; bcd_in = 12'h123;
    @(posedge clk); #1;
    start = 1'b0; bcd_in = 12'h000;
    ndone = 0; first = -1; b = 8'h00;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin start = 1'b1; bcd_in = 12'h456; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first < 0) begin first = c; b = bin_out; end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (ndone !== 1 || first !== 12) begin
      n_err++; $display("FAIL ignore_start_done: got %0d pulses first at %0d, want 1 at 12", ndone, first);
    end
    n_cmp++;
    if (b !== 8'h7B) begin n_err++; $display("FAIL ignore_start_value: got %h want 7B", b); end
  endtask

  task automatic test_reset_abort();
    int ndone, lat, bb, dc; logic [7:0] b; logic o, e;
    start = 1'b1; bcd_in = 12'h200;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, bin_out, overflow, bcd_err} !== 12'h000) begin
      n_err++;
      $display("FAIL abort_outputs: got busy=%b done=%b bin=%h ov=%b err=%b, want all 0",
               busy, done, bin_out, overflow, bcd_err);
    end
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    do_conv(12'h042, lat, b, o, e, bb, dc);
    n_cmp++;
    if ({b, o, e} !== {8'h2A, 1'b0, 1'b0} || lat !== 12) begin
      n_err++; $display("FAIL abort_recover: got bin=%h ov=%b err=%b lat=%0d want 2A 0 0 12", b, o, e, lat);
    end
  endtask

  task automatic test_random();
    int lat, bb, dc, mlat; logic [7:0] b, mb; logic o, e, mo, me;
    logic [11:0] v;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 3; i++) v[4*i +: 4] = 4'($urandom_range(0, 11));
      model(v, mlat, mb, mo, me);
      do_conv(v, lat, b, o, e, bb, dc);
      n_cmp++;
      if (lat !== mlat || b !== mb || o !== mo || e !== me || bb !== 0) begin
        n_err++;
        $display("FAIL random[%0d] bcd=%h: got lat=%0d bin=%h ov=%b err=%b busylow=%0d want %0d %h %b %b 0",
                 k, v, lat, b, o, e, bb, mlat, mb, mo, me);
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bcd_in = 12'h000;
    test_reset();
    test_max_fit();
    test_back_to_back();
    test_overflow();
    test_bcd_err();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
